// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: groups the start/stall/redirect/halt controls, the ROM
// address/data pair and the fetch-register outputs between the fetch
// controller and its neighbours (ROM, decode, execute).
interface inst_fetch_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic         Start;
    logic [A-1:0] StartAddr;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstIn;
    logic         Stall;
    logic         BranchTaken;
    logic [A-1:0] BranchTarget;
    logic         Halt;
    logic [W-1:0] InstReg;
    logic [A-1:0] InstPC;
    logic         InstValid;
    logic         Done;
    logic [31:0]  CycleCount;

    // Fetch controller side: owns the address and the fetch register.
    modport master (
        input  Start, StartAddr, InstIn, Stall, BranchTaken, BranchTarget, Halt,
        output InstAddress, InstReg, InstPC, InstValid, Done, CycleCount
    );

    // Environment side: ROM, decode and execute stages.
    modport slave (
        output Start, StartAddr, InstIn, Stall, BranchTaken, BranchTarget, Halt,
        input  InstAddress, InstReg, InstPC, InstValid, Done, CycleCount
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: program counter, ROM addressing and one-entry fetch register
// with start, stall, taken-branch flush and halt handling.
// Optional feature macro: FETCH_CYCLE_CNT_EN builds the saturating RUN-state
// cycle counter; without it CycleCount is tied to zero.
module inst_fetch #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic          Clk,
    input  logic          Reset,
    inst_fetch_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

    state_t       state_r, state_s;
    logic [A-1:0] pc_r, pc_s;
    logic [W-1:0] inst_reg_r, inst_reg_s;
    logic [A-1:0] inst_pc_r, inst_pc_s;
    logic         inst_valid_r, inst_valid_s;
    logic         done_r, done_s;

    // State register: Reset dominates everything else.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: Start (re)enters RUN from any state; a halt only
    // counts when the fetch register holds a live instruction.
    always_comb begin
        state_s = state_r;
        if (bus.Start) begin
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_IDLE;
                ST_RUN: begin
                    if (bus.Halt && inst_valid_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: priority Halt > Stall > BranchTaken > sequential.
    // A taken branch drops the word arriving this cycle, giving one bubble.
    always_comb begin
        pc_s         = pc_r;
        inst_reg_s   = inst_reg_r;
        inst_pc_s    = inst_pc_r;
        inst_valid_s = inst_valid_r;
        done_s       = done_r;
        if (bus.Start) begin
            pc_s         = bus.StartAddr;
            inst_valid_s = 1'b0;
            done_s       = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.Halt && inst_valid_r) begin
                        inst_valid_s = 1'b0;
                        done_s       = 1'b1;
                    end else if (bus.Stall) begin
                        inst_valid_s = inst_valid_r;
                    end else if (bus.BranchTaken && inst_valid_r) begin
                        pc_s         = bus.BranchTarget;
                        inst_valid_s = 1'b0;
                    end else begin
                        inst_reg_s   = bus.InstIn;
                        inst_pc_s    = pc_r;
                        inst_valid_s = 1'b1;
                        pc_s         = pc_r + PC_ONE;
                    end
                end
                ST_DONE: begin
                    inst_valid_s = 1'b0;
                    done_s       = 1'b1;
                end
                ST_IDLE: begin
                    inst_valid_s = inst_valid_r;
                end
                default: begin
                    inst_valid_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r         <= {A{1'b0}};
            inst_reg_r   <= {W{1'b0}};
            inst_pc_r    <= {A{1'b0}};
            inst_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            pc_r         <= pc_s;
            inst_reg_r   <= inst_reg_s;
            inst_pc_r    <= inst_pc_s;
            inst_valid_r <= inst_valid_s;
            done_r       <= done_s;
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_r;

    // RUN-state cycle counter, stalls included, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_cnt_r <= 32'd0;
        end else if (bus.Start) begin
            cycle_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign bus.CycleCount = cycle_cnt_r;
`else
    assign bus.CycleCount = 32'd0;
`endif

    assign bus.InstAddress = pc_r;
    assign bus.InstReg     = inst_reg_r;
    assign bus.InstPC      = inst_pc_r;
    assign bus.InstValid   = inst_valid_r;
    assign bus.Done        = done_r;
endmodule
